// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WRITE = 2'd2
    } state_e;

    // RV32I width/sign encodings carried on funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signless widths; loads add the unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select by offset, then sign- or zero-extend by funct3.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h000000, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0000, half_sel};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data memory
// with registered reads. Sub-word stores are done as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [2:0]    funct3,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          err,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wd,
    output logic          dm_wen,
    input  logic [31:0]   dm_rd
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    // Only the low half of store data is ever merged into memory.
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   load_data;
    logic [31:0]   merged;

    lsu_load_align u_align (
        .word   (dm_rd),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .rdata  (load_data)
    );

    // Overlay the stored byte/half onto the word just read back.
    always_comb begin
        merged = dm_rd;
        if (funct3_q == F3_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Next state and per-cycle outputs; outputs react to req in IDLE the same cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        stall    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        rdata    = 32'h0;
        dm_addr  = {addr_q[AW-1:2], 2'b00};
        dm_wd    = 32'h0;
        dm_wen   = 1'b0;
        case (state_q)
            IDLE: begin
                dm_addr = {addr[AW-1:2], 2'b00};
                if (req) begin
                    if (!f3_legal(we, funct3) || f3_misaligned(funct3, addr[1:0])) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else if (we && funct3 == F3_W) begin
                        dm_wd  = wdata;
                        dm_wen = 1'b1;
                        done   = 1'b1;
                    end else begin
                        // Read the word now; it is consumed next cycle.
                        stall    = 1'b1;
                        addr_d   = addr;
                        funct3_d = funct3;
                        if (we) begin
                            wdata_d = wdata[15:0];
                            state_d = RMW_WRITE;
                        end else begin
                            state_d = LOAD_WAIT;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                rdata   = load_data;
                done    = 1'b1;
                state_d = IDLE;
            end
            RMW_WRITE: begin
                dm_wd   = merged;
                dm_wen  = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset silences the memory port and pipeline handshake at once.
        if (!rst) begin
            stall   = 1'b0;
            done    = 1'b0;
            err     = 1'b0;
            rdata   = 32'h0;
            dm_addr = '0;
            dm_wd   = 32'h0;
            dm_wen  = 1'b0;
        end
    end

    // State and captured request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a registered-read word memory model.
module tb_lsu_ctrl;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          stall;
    logic          done;
    logic [31:0]   rdata;
    logic          err;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wd;
    logic          dm_wen;
    logic [31:0]   dm_rd;

    int vectors = 0;
    int miscompares = 0;
    int wen_total = 0;

    typedef struct {
        logic got, err, wen, stall_done;
        logic [31:0] rdata, wd, daddr;
        int stalls, cycles, wens;
        logic [3:0] pat;
    } obs_t;

    typedef struct {
        logic err, wen, chk_addr;
        logic [31:0] rdata, wd, daddr;
        int stalls;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    lsu_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .err(err),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_wen(dm_wen), .dm_rd(dm_rd)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'h80FF1234;
            8:       return 32'h11223344;
            16:      return 32'h8001C0DE;
            default: return (i * 32'h01030507) ^ 32'h5A5AA5A5;
        endcase
    endfunction

    // Data memory: synchronous write, registered read; reloads while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (dm_wen) begin
            mem[dm_addr[7:2]] <= dm_wd;
        end
        dm_rd <= mem[dm_addr[7:2]];
    end

    always @(negedge clk) if (dm_wen) wen_total <= wen_total + 1;

    task automatic reset_model();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic exp_t mk_exp(input logic e_err, input logic e_wen, input logic [31:0] e_rdata,
                                    input logic [31:0] e_wd, input logic [31:0] e_daddr, input int e_stalls);
        exp_t e;
        e.err = e_err; e.wen = e_wen; e.chk_addr = !e_err;
        e.rdata = e_rdata; e.wd = e_wd; e.daddr = e_daddr; e.stalls = e_stalls;
        return e;
    endfunction

    // Reference behaviour computed from the bench's own copy of memory.
    function automatic exp_t model(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        logic legal, mis;
        logic [31:0] word, sh, mask, nw, rd;
        int sz;
        sz = int'(f[1:0]);
        legal = w ? (f <= 3'd2) : (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
        if (!legal || mis) return mk_exp(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        word = ref_mem[a[7:2]];
        sh = word >> (8 * a[1:0]);
        if (!w) begin
            case (sz)
                0:       rd = f[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                1:       rd = f[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                default: rd = word;
            endcase
            return mk_exp(1'b0, 1'b0, rd, 32'h0, {a[31:2], 2'b00}, 1);
        end
        mask = (sz == 0) ? 32'h000000FF : (sz == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        mask = mask << (8 * a[1:0]);
        nw = (word & ~mask) | ((d << (8 * a[1:0])) & mask);
        ref_mem[a[7:2]] = nw;
        return mk_exp(1'b0, 1'b1, 32'h0, nw, {a[31:2], 2'b00}, (sz == 2) ? 0 : 1);
    endfunction

    // Drive one request from posedge+1 and collect what the DUT did until done.
    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, output obs_t o);
        o.got = 0; o.err = 0; o.wen = 0; o.stall_done = 0;
        o.rdata = 0; o.wd = 0; o.daddr = 0; o.stalls = 0; o.cycles = 0; o.wens = 0; o.pat = 0;
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        for (int c = 0; c < 6 && !o.got; c++) begin
            @(negedge clk);
            o.cycles++;
            o.pat = {o.pat[2:0], stall};
            if (dm_wen) o.wens++;
            if (done) begin
                o.got = 1'b1; o.err = err; o.rdata = rdata; o.wd = dm_wd;
                o.daddr = dm_addr; o.wen = dm_wen; o.stall_done = stall;
            end else if (stall) begin
                o.stalls++;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", stall); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        vectors++; if (dm_wen !== 1'b0) begin miscompares++; $display("FAIL rst_wen got %b want 0", dm_wen); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata); end
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall_clk got %b want 0", stall); end
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++; if ({stall, done, err, dm_wen} !== 4'b0000) begin miscompares++; $display("FAIL idle_noreq got %b want 0000", {stall, done, err, dm_wen}); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  ft [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010, 3'b100};
        logic [31:0] at [8] = '{32'h13, 32'h13, 32'h11, 32'h12, 32'h12, 32'h10, 32'h10, 32'h10};
        logic [31:0] rt [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000012, 32'hFFFF80FF,
                                32'h000080FF, 32'h00001234, 32'h80FF1234, 32'h00000034};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk_exp(1'b0, 1'b0, rt[i], 32'h0, 32'h10, 1));
            issue(1'b0, ft[i], at[i], 32'h0, o);
            e = exp_q.pop_front();
            vectors++; if (o.got !== 1'b1) begin miscompares++; $display("FAIL ld_done[%0d] got %b want 1", i, o.got); end
            vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL ld_rdata[%0d] got %h want %h", i, o.rdata, e.rdata); end
            vectors++; if (o.stalls !== e.stalls || o.stall_done !== 1'b0) begin miscompares++; $display("FAIL ld_stall[%0d] got %0d/%b want %0d/0", i, o.stalls, o.stall_done, e.stalls); end
            vectors++; if (o.daddr !== e.daddr || o.err !== 1'b0 || o.wens !== 0) begin miscompares++; $display("FAIL ld_side[%0d] got addr %h err %b wens %0d want %h 0 0", i, o.daddr, o.err, o.wens, e.daddr); end
        end
    endtask

    task automatic test_store_word();
        obs_t o;
        exp_t e;
        exp_q.push_back(mk_exp(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 32'h10, 0));
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
        e = exp_q.pop_front();
        vectors++; if (o.cycles !== 1 || o.got !== 1'b1 || o.stall_done !== 1'b0) begin miscompares++; $display("FAIL sw_timing got cycles %0d done %b stall %b want 1 1 0", o.cycles, o.got, o.stall_done); end
        vectors++; if (o.wen !== e.wen) begin miscompares++; $display("FAIL sw_wen got %b want %b", o.wen, e.wen); end
        vectors++; if (o.daddr !== e.daddr) begin miscompares++; $display("FAIL sw_addr got %h want %h", o.daddr, e.daddr); end
        vectors++; if (o.wd !== e.wd) begin miscompares++; $display("FAIL sw_wd got %h want %h", o.wd, e.wd); end
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h10, 1));
        issue(1'b0, 3'b010, 32'h10, 32'h0, o);
        e = exp_q.pop_front();
        vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL sw_readback got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_store_merge();
        logic        wt [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  ft [5] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b010};
        logic [31:0] at [5] = '{32'h22, 32'h21, 32'h23, 32'h20, 32'h20};
        logic [31:0] dt [5] = '{32'h0000ABCD, 32'hFFFFFF99, 32'h00000001, 32'h55557777, 32'h0};
        logic [31:0] xt [5] = '{32'hABCD3344, 32'hABCD9944, 32'h01CD9944, 32'h01CD7777, 32'h01CD7777};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (wt[i]) exp_q.push_back(mk_exp(1'b0, 1'b1, 32'h0, xt[i], 32'h20, 1));
            else       exp_q.push_back(mk_exp(1'b0, 1'b0, xt[i], 32'h0, 32'h20, 1));
            issue(wt[i], ft[i], at[i], dt[i], o);
            e = exp_q.pop_front();
            vectors++; if (o.got !== 1'b1 || o.stalls !== e.stalls || o.stall_done !== 1'b0) begin miscompares++; $display("FAIL rmw_timing[%0d] got done %b stalls %0d want 1 %0d", i, o.got, o.stalls, e.stalls); end
            vectors++; if (o.wen !== e.wen || o.wens !== (e.wen ? 1 : 0)) begin miscompares++; $display("FAIL rmw_wen[%0d] got %b/%0d want %b", i, o.wen, o.wens, e.wen); end
            vectors++; if ((e.wen ? o.wd : o.rdata) !== (e.wen ? e.wd : e.rdata)) begin miscompares++; $display("FAIL rmw_data[%0d] got wd %h rd %h want %h", i, o.wd, o.rdata, e.wen ? e.wd : e.rdata); end
            vectors++; if (o.daddr !== e.daddr) begin miscompares++; $display("FAIL rmw_addr[%0d] got %h want %h", i, o.daddr, e.daddr); end
        end
    endtask

    task automatic test_errors();
        logic        wt [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ft [9] = '{3'b010, 3'b011, 3'b001, 3'b101, 3'b010, 3'b001, 3'b100, 3'b110, 3'b111};
        logic [31:0] at [9] = '{32'h06, 32'h00, 32'h01, 32'h03, 32'h02, 32'h03, 32'h00, 32'h04, 32'h08};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 0));
            issue(wt[i], ft[i], at[i], 32'hCAFEF00D, o);
            e = exp_q.pop_front();
            vectors++; if (o.got !== 1'b1 || o.cycles !== 1 || o.stall_done !== 1'b0) begin miscompares++; $display("FAIL err_timing[%0d] got done %b cycles %0d stall %b want 1 1 0", i, o.got, o.cycles, o.stall_done); end
            vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL err_flag[%0d] got %b want %b", i, o.err, e.err); end
            vectors++; if (o.wens !== 0 || o.rdata !== e.rdata) begin miscompares++; $display("FAIL err_side[%0d] got wens %0d rdata %h want 0 0", i, o.wens, o.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        exp_t e;
        int w0;
        w0 = wen_total;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'hFFFFC0DE, 32'h0, 32'h40, 1));
        exp_q.push_back(mk_exp(1'b0, 1'b1, 32'h0, 32'h80015ADE, 32'h40, 1));
        issue(1'b0, 3'b001, 32'h40, 32'h0, o1);
        issue(1'b1, 3'b000, 32'h41, 32'h0000005A, o2);
        e = exp_q.pop_front();
        vectors++; if (o1.rdata !== e.rdata) begin miscompares++; $display("FAIL b2b_lh got %h want %h", o1.rdata, e.rdata); end
        e = exp_q.pop_front();
        vectors++; if (o2.wd !== e.wd || o2.wen !== e.wen) begin miscompares++; $display("FAIL b2b_sb got %h/%b want %h/1", o2.wd, o2.wen, e.wd); end
        vectors++; if (o1.cycles + o2.cycles !== 4) begin miscompares++; $display("FAIL b2b_cycles got %0d want 4", o1.cycles + o2.cycles); end
        vectors++; if ({o1.pat[1:0], o2.pat[1:0]} !== 4'b1010) begin miscompares++; $display("FAIL b2b_stall got %b want 1010", {o1.pat[1:0], o2.pat[1:0]}); end
        vectors++; if (wen_total - w0 !== 1) begin miscompares++; $display("FAIL b2b_wen_count got %0d want 1", wen_total - w0); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int w0;
        w0 = wen_total;
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h31; wdata = 32'h77;
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mid_accept got stall %b want 1", stall); end
        rst = 1'b0;
        #1;
        vectors++; if ({stall, done, err, dm_wen} !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_out got %b want 0000", {stall, done, err, dm_wen}); end
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if (dm_wen !== 1'b0 || rdata !== 32'h0) begin miscompares++; $display("FAIL mid_hold[%0d] got wen %b rdata %h want 0 0", i, dm_wen, rdata); end
        end
        rst = 1'b1;
        reset_model();
        @(posedge clk); #1;
        vectors++; if (wen_total !== w0) begin miscompares++; $display("FAIL mid_no_write got %0d writes want 0", wen_total - w0); end
        exp_q.push_back(model(1'b1, 3'b010, 32'h30, 32'h12345678));
        issue(1'b1, 3'b010, 32'h30, 32'h12345678, o);
        e = exp_q.pop_front();
        vectors++; if (o.cycles !== 1 || o.wen !== 1'b1 || o.wd !== e.wd) begin miscompares++; $display("FAIL mid_first_sw got cycles %0d wen %b wd %h want 1 1 %h", o.cycles, o.wen, o.wd, e.wd); end
        exp_q.push_back(model(1'b0, 3'b100, 32'h31, 32'h0));
        issue(1'b0, 3'b100, 32'h31, 32'h0, o);
        e = exp_q.pop_front();
        vectors++; if (o.rdata !== e.rdata || o.stalls !== 1) begin miscompares++; $display("FAIL mid_lbu got %h/%0d want %h/1", o.rdata, o.stalls, e.rdata); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic w;
        logic [2:0] f;
        logic [31:0] a, d;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            d = $urandom;
            exp_q.push_back(model(w, f, a, d));
            issue(w, f, a, d, o);
            e = exp_q.pop_front();
            vectors++;
            if (o.got !== 1'b1 || o.err !== e.err || o.stalls !== e.stalls || o.wen !== e.wen || o.rdata !== e.rdata
                || (e.wen && o.wd !== e.wd) || (e.chk_addr && o.daddr !== e.daddr)) begin
                miscompares++;
                $display("FAIL rnd[%0d] we %b f3 %b addr %h: got err %b st %0d wen %b rd %h wd %h da %h want %b %0d %b %h %h %h",
                         i, w, f, a, o.err, o.stalls, o.wen, o.rdata, o.wd, o.daddr, e.err, e.stalls, e.wen, e.rdata, e.wd, e.daddr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = 32'h0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_load_ext();
        test_store_word();
        test_store_merge();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 32: byte-address width on both sides.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 1: pipeline MEM-stage access request, held stable while stall=1.
REQ-005 The block SHALL have port we, input, 1: 1=store, 0=load.
REQ-006 The block SHALL have port funct3, input, 3: RV32I width/sign code.
REQ-007 The block SHALL have port addr, input, AW: byte address from ALU output.
REQ-008 The block SHALL have port wdata, input, 32: store data, right-aligned.
REQ-009 The block SHALL have port stall, output, 1: freeze pipeline this cycle.
REQ-010 The block SHALL have port done, output, 1: access completes this cycle.
REQ-011 The block SHALL have port rdata, output, 32: extended load data, valid when done=1 and load; 0 otherwise.
REQ-012 The block SHALL have port err, output, 1: misaligned address or illegal funct3; pulses with done.
REQ-013 The block SHALL have port dm_addr, output, AW: word-aligned memory address (bits[1:0]=0).
REQ-014 The block SHALL have port dm_wd, output, 32: memory write word.
REQ-015 The block SHALL have port dm_wen, output, 1: memory write enable (synchronous write).
REQ-016 The block SHALL have port dm_rd, input, 32: memory read word, valid one cycle after dm_addr is presented (registered read).

Function
REQ-017 FSM states SHALL be IDLE, LOAD_WAIT and RMW_WRITE; only IDLE samples req.
REQ-018 Legal codes SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others are illegal.
REQ-019 Misalignment SHALL be halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 IDLE, req=1 and (illegal or misaligned): done=1, err=1, stall=0, dm_wen=0, stay IDLE, no memory access.
REQ-021 IDLE, req=1, SW: dm_addr=addr, dm_wd=wdata, dm_wen=1, done=1, stall=0, stay IDLE (1 cycle).
REQ-022 IDLE, req=1, load: present dm_addr, register addr[1:0] and funct3, stall=1, go to LOAD_WAIT.
REQ-023 LOAD_WAIT: select the byte or half indexed by registered addr[1:0] from dm_rd; sign-extend (LB, LH) or zero-extend (LBU, LHU); rdata=result, done=1, stall=0; go to IDLE (2 cycles total).
REQ-024 IDLE, req=1, SB/SH: present dm_addr, register addr, funct3 and wdata, stall=1, go to RMW_WRITE.
REQ-025 RMW_WRITE: dm_wd=dm_rd with the target byte or half replaced by wdata[7:0] or wdata[15:0]; dm_wen=1, dm_addr held, done=1, stall=0; go to IDLE.
REQ-026 req in LOAD_WAIT and RMW_WRITE SHALL be ignored (same instruction, held by the stall).
REQ-027 req=0 in IDLE: stall=0, done=0, err=0, dm_wen=0.
REQ-028 dm_wen SHALL never be asserted outside REQ-021 and REQ-025; back-to-back requests SHALL be accepted in the IDLE cycle after completion.

Reset
REQ-029 rst=0 SHALL force state to IDLE and clear the registered addr, funct3 and wdata to 0 immediately, with stall=0, done=0, err=0, dm_wen=0 and rdata=0.
REQ-030 Reset mid-operation SHALL abandon the access with no write issued; the first access after reset release follows REQ-020 to REQ-025.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum and the funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-032 Sub-module lsu_load_align SHALL be the combinational byte/half select and extend (inputs word, offset, funct3; output rdata).
REQ-033 FSM and merge logic SHALL live in lsu_ctrl.

Verification
REQ-034 SW: addr=0x10, wdata=0xDEADBEEF -> same cycle dm_wen=1, dm_addr=0x10, dm_wd=0xDEADBEEF, done=1, stall=0.
REQ-035 LB: addr=0x13, memory word 0x80FF1234 -> stall 1 cycle, then rdata=0xFFFFFF80, done=1; LBU at the same address -> 0x00000080.
REQ-036 SH: addr=0x22, wdata=0x0000ABCD, old word 0x11223344 -> stall 1 cycle, then dm_wen=1, dm_wd=0xABCD3344.
REQ-037 LW: addr=0x06 -> err=1, done=1, stall=0, dm_wen=0; funct3=011 load -> err=1.
REQ-038 rst=0 asserted in RMW_WRITE's preceding cycle (after SB accept) -> no dm_wen, state IDLE, outputs 0.
REQ-039 Back-to-back LH 0x40 then SB 0x41 -> 4 cycles total, stall pattern 1,0,1,0, exactly one dm_wen.
